// File: rtl/pu_sequencer_if.sv
// Bus between the PU sequencer and its surroundings: buffer-load port,
// run control, PU operand/result lanes and the per-row result stream.
// slave: the sequencer side; master: the load path / PU / result consumer.
interface pu_sequencer_if #(
   parameter int WIDTH = 32,
   parameter int LEN   = 8,
   parameter int ROWS  = 2
);
   localparam int AW = $clog2(ROWS * LEN);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic             wr_en;
   logic             wr_sel;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             start;
   logic             busy;
   logic             pu_en;
   logic [WIDTH-1:0] pu_x1, pu_x2, pu_x3, pu_x4;
   logic [WIDTH-1:0] pu_w1, pu_w2, pu_w3, pu_w4;
   logic [WIDTH-1:0] pu_data;
   logic             out_valid;
   logic [RW-1:0]    out_row;
   logic [WIDTH-1:0] out_data;
   logic             done;

   modport master (
      output wr_en, wr_sel, wr_addr, wr_data, start, pu_data,
      input  busy, pu_en, pu_x1, pu_x2, pu_x3, pu_x4,
             pu_w1, pu_w2, pu_w3, pu_w4, out_valid, out_row, out_data, done
   );

   modport slave (
      input  wr_en, wr_sel, wr_addr, wr_data, start, pu_data,
      output busy, pu_en, pu_x1, pu_x2, pu_x3, pu_x4,
             pu_w1, pu_w2, pu_w3, pu_w4, out_valid, out_row, out_data, done
   );
endinterface

// File: rtl/pu_sequencer.sv
// PU sequencer: holds an x vector and ROWS weight rows, streams them to the
// PU four lanes per cycle, and accumulates pu_data into one dot product per row.
// Optional feature macro: RELU_EN -- clamps negative results to zero at the
// result stage only (the accumulator itself stays raw).
module pu_sequencer #(
   parameter int WIDTH = 32,
   parameter int LEN   = 8,
   parameter int ROWS  = 2
) (
   input logic           clk,
   input logic           rst,
   pu_sequencer_if.slave bus
);
   localparam int CPR = LEN / 4;
   localparam int AW  = $clog2(ROWS * LEN);
   localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW  = (CPR > 1) ? $clog2(CPR) : 1;

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] x_buf [LEN];
   logic [WIDTH-1:0] w_buf [ROWS*LEN];
   logic [WIDTH-1:0] x_nx  [LEN];
   logic [WIDTH-1:0] w_nx  [ROWS*LEN];
   logic [WIDTH-1:0] x_lane [4];
   logic [WIDTH-1:0] w_lane [4];
   logic [RW-1:0]    row_cnt, row_nx;
   logic [CW-1:0]    chk_cnt, chk_nx;
   logic             launch, advance;
   logic             cap_v, cap_first, cap_last;
   logic [RW-1:0]    cap_row;
   logic [WIDTH-1:0] acc, acc_nx, res;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state, chunk issue control and status outputs
   always_comb begin
      state_nx  = state;
      launch    = 1'b0;
      advance   = 1'b0;
      bus.busy  = 1'b0;
      bus.pu_en = 1'b0;
      bus.done  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nx = FEED;
               launch   = 1'b1;
            end
         end
         FEED: begin
            bus.busy  = 1'b1;
            bus.pu_en = 1'b1;
            if (row_cnt == RW'(ROWS - 1) && chk_cnt == CW'(CPR - 1)) state_nx = DRAIN;
            else                                                       advance  = 1'b1;
         end
         DRAIN: begin
            bus.busy = 1'b1;
            if (bus.out_valid && bus.out_row == RW'(ROWS - 1)) state_nx = DONE;
         end
         DONE: begin
            bus.done = 1'b1;
            if (bus.start) begin
               state_nx = FEED;
               launch   = 1'b1;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Buffer contents after this cycle's write; chunk 0 of a run reads this
   // view so a write coinciding with start is already visible to the run.
   always_comb begin
      x_nx = x_buf;
      w_nx = w_buf;
      if (bus.wr_en && !bus.busy) begin
         if (!bus.wr_sel) begin
            for (int unsigned k = 0; k < LEN; k++)
               if (bus.wr_addr == AW'(k)) x_nx[k] = bus.wr_data;
         end else begin
            for (int unsigned k = 0; k < ROWS * LEN; k++)
               if (bus.wr_addr == AW'(k)) w_nx[k] = bus.wr_data;
         end
      end
   end

   // Next chunk position and the four operand lanes it selects
   always_comb begin
      row_nx = row_cnt;
      chk_nx = chk_cnt;
      if (launch) begin
         row_nx = '0;
         chk_nx = '0;
      end else if (advance) begin
         if (chk_cnt == CW'(CPR - 1)) begin
            chk_nx = '0;
            row_nx = row_cnt + 1'b1;
         end else begin
            chk_nx = chk_cnt + 1'b1;
         end
      end
      x_lane = '{default: '0};
      w_lane = '{default: '0};
      for (int unsigned k = 0; k < LEN; k++)
         if (CW'(k / 4) == chk_nx) x_lane[k % 4] = x_nx[k];
      for (int unsigned r = 0; r < ROWS; r++)
         for (int unsigned k = 0; k < LEN; k++)
            if (RW'(r) == row_nx && CW'(k / 4) == chk_nx) w_lane[k % 4] = w_nx[r * LEN + k];
   end

   // Accumulate and result-stage value
   always_comb begin
      acc_nx = cap_first ? bus.pu_data : acc + bus.pu_data;
`ifdef RELU_EN
      res = acc_nx[WIDTH-1] ? '0 : acc_nx;
`else
      res = acc_nx;
`endif
   end

   // Buffers, operand registers, capture pipeline and result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         x_buf         <= '{default: '0};
         w_buf         <= '{default: '0};
         row_cnt       <= '0;
         chk_cnt       <= '0;
         bus.pu_x1     <= '0;
         bus.pu_x2     <= '0;
         bus.pu_x3     <= '0;
         bus.pu_x4     <= '0;
         bus.pu_w1     <= '0;
         bus.pu_w2     <= '0;
         bus.pu_w3     <= '0;
         bus.pu_w4     <= '0;
         cap_v         <= 1'b0;
         cap_first     <= 1'b0;
         cap_last      <= 1'b0;
         cap_row       <= '0;
         acc           <= '0;
         bus.out_valid <= 1'b0;
         bus.out_row   <= '0;
         bus.out_data  <= '0;
      end else begin
         x_buf <= x_nx;
         w_buf <= w_nx;
         if (launch || advance) begin
            row_cnt   <= row_nx;
            chk_cnt   <= chk_nx;
            bus.pu_x1 <= x_lane[0];
            bus.pu_x2 <= x_lane[1];
            bus.pu_x3 <= x_lane[2];
            bus.pu_x4 <= x_lane[3];
            bus.pu_w1 <= w_lane[0];
            bus.pu_w2 <= w_lane[1];
            bus.pu_w3 <= w_lane[2];
            bus.pu_w4 <= w_lane[3];
         end
         // Tag the chunk on the PU this cycle; its sum shows up next cycle.
         cap_v         <= bus.pu_en;
         cap_first     <= (chk_cnt == '0);
         cap_last      <= (chk_cnt == CW'(CPR - 1));
         cap_row       <= row_cnt;
         bus.out_valid <= 1'b0;
         if (cap_v) begin
            acc <= acc_nx;
            if (cap_last) begin
               bus.out_valid <= 1'b1;
               bus.out_row   <= cap_row;
               bus.out_data  <= res;
            end
         end
      end
   end
endmodule

// File: tb/tb_pu_sequencer.sv
// Bench for pu_sequencer: a LEN=8/ROWS=2 instance for the main scenarios and a
// LEN=4/ROWS=1 instance for wrap-around. Each instance sees a behavioural PU
// (one-cycle registered sum of products). Expected row results go to a
// scoreboard queue when a run starts and are popped as out_valid appears.
module tb_pu_sequencer;
   localparam int NM   = 4;   // chunks per run, main instance
   localparam int CPRM = 2;   // chunks per row, main instance

   typedef struct packed {
      logic [0:0]  row;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   logic [31:0] xm [8];
   logic [31:0] wm [16];
   exp_t        sbm [$];
   logic [31:0] sbs [$];
   logic [31:0] pum = '0;
   logic [31:0] pus = '0;

   always #5 clk = ~clk;

   pu_sequencer_if #(.WIDTH(32), .LEN(8), .ROWS(2)) bm ();
   pu_sequencer_if #(.WIDTH(32), .LEN(4), .ROWS(1)) bs ();

   pu_sequencer #(.WIDTH(32), .LEN(8), .ROWS(2)) dut_m (.clk(clk), .rst(rst), .bus(bm.slave));
   pu_sequencer #(.WIDTH(32), .LEN(4), .ROWS(1)) dut_s (.clk(clk), .rst(rst), .bus(bs.slave));

   // Behavioural PUs
   always @(posedge clk) begin
      if (bm.pu_en === 1'b1)
         pum <= bm.pu_x1 * bm.pu_w1 + bm.pu_x2 * bm.pu_w2 + bm.pu_x3 * bm.pu_w3 + bm.pu_x4 * bm.pu_w4;
      if (bs.pu_en === 1'b1)
         pus <= bs.pu_x1 * bs.pu_w1 + bs.pu_x2 * bs.pu_w2 + bs.pu_x3 * bs.pu_w3 + bs.pu_x4 * bs.pu_w4;
   end
   assign bm.pu_data = pum;
   assign bs.pu_data = pus;

   function automatic logic [31:0] dot(input int r);
      logic [31:0] s;
      s = '0;
      for (int k = 0; k < 8; k++) s = s + xm[k] * wm[r * 8 + k];
`ifdef RELU_EN
      if (s[31]) s = '0;
`endif
      return s;
   endfunction

   task automatic set_pattern();
      for (int k = 0; k < 8; k++) begin
         xm[k]     = 32'(k + 1);
         wm[k]     = 32'd1;
         wm[8 + k] = 32'hFFFF_FFFF;
      end
   endtask

   task automatic load_main();
      @(posedge clk); #1;
      for (int k = 0; k < 8; k++) begin
         bm.wr_en = 1'b1; bm.wr_sel = 1'b0; bm.wr_addr = 4'(k); bm.wr_data = xm[k];
         @(posedge clk); #1;
      end
      for (int k = 0; k < 16; k++) begin
         bm.wr_en = 1'b1; bm.wr_sel = 1'b1; bm.wr_addr = 4'(k); bm.wr_data = wm[k];
         @(posedge clk); #1;
      end
      bm.wr_en = 1'b0;
   endtask

   // Drives the main instance for ncyc cycles starting at cycle 0 (entered just
   // after a rising edge) and checks every cycle against the timing model.
   // s0/s1: start cycles of runs (-1 none); rst_cyc: reset pulse cycle;
   // ign_cyc: cycle of a stray start + write to w[0]; co_wr: write x[0]=10 with start.
   task automatic watch(input int ncyc, input int s0, input int s1, input int rst_cyc,
                        input int ign_cyc, input bit co_wr);
      int   runs [2];
      int   t, chunk;
      logic exp_en, exp_busy, exp_done, exp_ov;
      exp_t e;
      runs[0] = s0;
      runs[1] = s1;
      for (int c = 0; c < ncyc; c++) begin
         bm.start = (c == s0 || c == s1 || c == ign_cyc);
         rst      = (c == rst_cyc);
         bm.wr_en = 1'b0;
         if (c == ign_cyc) begin
            bm.wr_en = 1'b1; bm.wr_sel = 1'b1; bm.wr_addr = '0; bm.wr_data = 32'h55;
         end
         if (co_wr && c == s0) begin
            bm.wr_en = 1'b1; bm.wr_sel = 1'b0; bm.wr_addr = '0; bm.wr_data = 32'd10;
            xm[0] = 32'd10;
         end
         if (c == s0 || c == s1) begin
            sbm.push_back('{row: 1'b0, data: dot(0)});
            sbm.push_back('{row: 1'b1, data: dot(1)});
         end
         exp_en = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_ov = 1'b0; chunk = -1;
         for (int k = 0; k < 2; k++) begin
            if (runs[k] >= 0 && c >= runs[k] && !(rst_cyc >= 0 && c > rst_cyc)) begin
               t = c - runs[k];
               if (t >= 1 && t <= NM) begin exp_en = 1'b1; chunk = t - 1; end
               if (t >= 1 && t <= NM + 2) exp_busy = 1'b1;
               if (t == NM + 3) exp_done = 1'b1;
               for (int r = 0; r < 2; r++)
                  if (t == 2 + CPRM * (r + 1)) exp_ov = 1'b1;
            end
         end
         @(negedge clk);
         total++;
         if (bm.pu_en !== exp_en) begin
            bad++; $display("FAIL pu_en cycle=%0d got=%b exp=%b", c, bm.pu_en, exp_en);
         end
         total++;
         if (bm.busy !== exp_busy) begin
            bad++; $display("FAIL busy cycle=%0d got=%b exp=%b", c, bm.busy, exp_busy);
         end
         total++;
         if (bm.done !== exp_done) begin
            bad++; $display("FAIL done cycle=%0d got=%b exp=%b", c, bm.done, exp_done);
         end
         total++;
         if (bm.out_valid !== exp_ov) begin
            bad++; $display("FAIL out_valid cycle=%0d got=%b exp=%b", c, bm.out_valid, exp_ov);
         end
         if (chunk >= 0) begin
            total++;
            if (bm.pu_x1 !== xm[4 * (chunk % CPRM)] ||
                bm.pu_w4 !== wm[(chunk / CPRM) * 8 + 4 * (chunk % CPRM) + 3]) begin
               bad++;
               $display("FAIL lanes cycle=%0d got x1=%h w4=%h exp x1=%h w4=%h", c, bm.pu_x1, bm.pu_w4,
                        xm[4 * (chunk % CPRM)], wm[(chunk / CPRM) * 8 + 4 * (chunk % CPRM) + 3]);
            end
         end
         if (rst_cyc >= 0 && c == rst_cyc + 1) begin
            total++;
            if (bm.out_data !== 32'd0 || bm.pu_x1 !== 32'd0 || bm.out_row !== 1'b0) begin
               bad++;
               $display("FAIL abort_clear got data=%h x1=%h row=%b exp 0", bm.out_data, bm.pu_x1, bm.out_row);
            end
         end
         if (bm.out_valid === 1'b1) begin
            total++;
            if (sbm.size() == 0) begin
               bad++; $display("FAIL result cycle=%0d unexpected row=%0d data=%h", c, bm.out_row, bm.out_data);
            end else begin
               e = sbm.pop_front();
               if (bm.out_row !== e.row || bm.out_data !== e.data) begin
                  bad++;
                  $display("FAIL result cycle=%0d got row=%0d data=%h exp row=%0d data=%h",
                           c, bm.out_row, bm.out_data, e.row, e.data);
               end
            end
         end
         @(posedge clk); #1;
      end
      bm.start = 1'b0;
      bm.wr_en = 1'b0;
      rst      = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bm.start = 1'b1;
      bs.start = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         @(negedge clk);
         total++;
         if (bm.busy !== 1'b0 || bm.pu_en !== 1'b0 || bm.out_valid !== 1'b0 || bm.done !== 1'b0 ||
             bm.out_data !== 32'd0 || bm.out_row !== 1'b0 || bm.pu_x1 !== 32'd0 || bm.pu_w4 !== 32'd0) begin
            bad++;
            $display("FAIL reset_main got busy=%b en=%b ov=%b done=%b data=%h x1=%h exp all 0",
                     bm.busy, bm.pu_en, bm.out_valid, bm.done, bm.out_data, bm.pu_x1);
         end
         total++;
         if (bs.busy !== 1'b0 || bs.pu_en !== 1'b0 || bs.out_valid !== 1'b0 || bs.out_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_small got busy=%b en=%b ov=%b data=%h exp all 0",
                     bs.busy, bs.pu_en, bs.out_valid, bs.out_data);
         end
      end
      rst = 1'b0;
      bm.start = 1'b0;
      bs.start = 1'b0;
      repeat (4) begin
         @(negedge clk);
         total++;
         if (bm.busy !== 1'b0 || bm.pu_en !== 1'b0 || bm.done !== 1'b0) begin
            bad++;
            $display("FAIL start_in_reset got busy=%b en=%b done=%b exp 0", bm.busy, bm.pu_en, bm.done);
         end
      end
   endtask

   task automatic test_basic();
      set_pattern();
      load_main();
      watch(12, 0, -1, -1, -1, 1'b0);
      total++;
      if (sbm.size() != 0) begin
         bad++; $display("FAIL basic_drain got pending=%0d exp 0", sbm.size());
      end
   endtask

   task automatic test_wrap();
      logic [31:0] e;
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
         bs.wr_en = 1'b1; bs.wr_sel = 1'b0; bs.wr_addr = 2'(k); bs.wr_data = 32'h7FFF_FFFF;
         @(posedge clk); #1;
      end
      for (int k = 0; k < 4; k++) begin
         bs.wr_en = 1'b1; bs.wr_sel = 1'b1; bs.wr_addr = 2'(k); bs.wr_data = 32'd1;
         @(posedge clk); #1;
      end
      bs.wr_en = 1'b0;
      bs.start = 1'b1;
      e = 32'hFFFF_FFFC;
`ifdef RELU_EN
      e = 32'd0;
`endif
      sbs.push_back(e);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         total++;
         if (bs.pu_en !== (c == 1) || bs.out_valid !== (c == 3) || bs.done !== (c == 4)) begin
            bad++;
            $display("FAIL wrap_timing cycle=%0d got en=%b ov=%b done=%b exp en=%b ov=%b done=%b",
                     c, bs.pu_en, bs.out_valid, bs.done, (c == 1), (c == 3), (c == 4));
         end
         if (bs.out_valid === 1'b1) begin
            total++;
            if (sbs.size() == 0) begin
               bad++; $display("FAIL wrap_result unexpected data=%h", bs.out_data);
            end else begin
               e = sbs.pop_front();
               if (bs.out_data !== e) begin
                  bad++; $display("FAIL wrap_result got=%h exp=%h", bs.out_data, e);
               end
            end
         end
         @(posedge clk); #1;
         bs.start = 1'b0;
      end
      total++;
      if (sbs.size() != 0) begin
         bad++; $display("FAIL wrap_drain got pending=%0d exp 0", sbs.size());
      end
   endtask

   task automatic test_ignore_busy();
      watch(12, 0, -1, -1, 2, 1'b0);
      total++;
      if (sbm.size() != 0) begin
         bad++; $display("FAIL ignore_drain got pending=%0d exp 0", sbm.size());
      end
   endtask

   task automatic test_back_to_back();
      watch(17, 0, NM + 3, -1, -1, 1'b0);
      total++;
      if (sbm.size() != 0) begin
         bad++; $display("FAIL b2b_drain got pending=%0d exp 0", sbm.size());
      end
   endtask

   task automatic test_abort();
      watch(10, 0, -1, 3, -1, 1'b0);
      total++;
      if (sbm.size() != 2) begin
         bad++; $display("FAIL abort_pending got=%0d exp=2", sbm.size());
      end
      sbm.delete();
      set_pattern();
      load_main();
      watch(12, 0, -1, -1, -1, 1'b1);
      total++;
      if (sbm.size() != 0) begin
         bad++; $display("FAIL reload_drain got pending=%0d exp 0", sbm.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      bm.wr_en = 1'b0; bm.wr_sel = 1'b0; bm.wr_addr = '0; bm.wr_data = '0; bm.start = 1'b0;
      bs.wr_en = 1'b0; bs.wr_sel = 1'b0; bs.wr_addr = '0; bs.wr_data = '0; bs.start = 1'b0;
      test_reset();
      test_basic();
      test_wrap();
      test_ignore_busy();
      test_back_to_back();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
